// File: rtl/pipelined_adder_pkg.sv
// Shared defaults and helpers for the pipelined ripple-carry adder.
// Optional signed-overflow output is enabled by defining PIPE_ADDER_OVF_EN.
package pipelined_adder_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_STAGES = 4;

  function automatic int unsigned chunk_width(input int unsigned w, input int unsigned s);
    return (s == 0) ? w : w / s;
  endfunction

  function automatic bit params_ok(input int unsigned w, input int unsigned s);
    return (s >= 1) && (s <= w) && ((w % s) == 0);
  endfunction

  // One full-adder cell: returns {carry_out, sum}
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

endpackage

// File: rtl/pipelined_adder_chunk.sv
// Combinational N-bit ripple-carry adder built from full-adder cells.
module pipelined_adder_chunk
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  always_comb begin : ripple
    logic       c;
    logic [1:0] fa;
    c   = cin;
    fa  = 2'b00;
    sum = '0;
    for (int i = 0; i < int'(N); i++) begin
      fa     = full_add(a[i], b[i], c);
      sum[i] = fa[0];
      c      = fa[1];
    end
    cout = c;
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: one CHUNK-bit slice per stage, valid/ready with bubble collapse.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    localparam int unsigned SRC  = WIDTH - k * CHUNK;
    localparam int unsigned REM  = WIDTH - (k + 1) * CHUNK;
    localparam int unsigned DONE = (k + 1) * CHUNK;

    logic             vld;
    logic             cy;
    logic             adv;
    logic             ld_vld;
    logic             ld_cin;
    logic [SRC-1:0]   src_a;
    logic [SRC-1:0]   src_b;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic [DONE-1:0]  done_d;
    logic [DONE-1:0]  done_q;

    // Stage inputs: top-level operands for stage 0, previous stage registers otherwise
    if (k == 0) begin : g_src_in
      assign ld_vld = in_valid;
      assign ld_cin = cin;
      assign src_a  = a;
      assign src_b  = b;
      assign done_d = chunk_sum;
    end else begin : g_src_prev
      assign ld_vld = g_stage[k-1].vld;
      assign ld_cin = g_stage[k-1].cy;
      assign src_a  = g_stage[k-1].g_rem.a_q;
      assign src_b  = g_stage[k-1].g_rem.b_q;
      assign done_d = {chunk_sum, g_stage[k-1].done_q};
    end

    // A stage may load when empty or when everything downstream moves
    if (k == int'(STAGES) - 1) begin : g_adv_last
      assign adv = ~vld | out_ready;
    end else begin : g_adv_mid
      assign adv = ~vld | g_stage[k+1].adv;
    end

    pipelined_adder_chunk #(.N(CHUNK)) u_chunk (
      .a    (src_a[CHUNK-1:0]),
      .b    (src_b[CHUNK-1:0]),
      .cin  (ld_cin),
      .sum  (chunk_sum),
      .cout (chunk_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin : stage_regs
      if (!rst_n) begin
        vld    <= 1'b0;
        cy     <= 1'b0;
        done_q <= '0;
      end else if (adv) begin
        vld    <= ld_vld;
        cy     <= chunk_cout;
        done_q <= done_d;
      end
    end

    // Operand bits not yet consumed travel with the op
    if (REM > 0) begin : g_rem
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;
      always_ff @(posedge clk or negedge rst_n) begin : rem_regs
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= src_a[SRC-1:CHUNK];
          b_q <= src_b[SRC-1:CHUNK];
        end
      end
    end

`ifdef PIPE_ADDER_OVF_EN
    logic src_am;
    logic src_bm;
    if (k == 0) begin : g_msb_in
      assign src_am = a[WIDTH-1];
      assign src_bm = b[WIDTH-1];
    end else begin : g_msb_prev
      assign src_am = g_stage[k-1].g_msb.am_q;
      assign src_bm = g_stage[k-1].g_msb.bm_q;
    end

    if (k < int'(STAGES) - 1) begin : g_msb
      logic am_q;
      logic bm_q;
      always_ff @(posedge clk or negedge rst_n) begin : msb_regs
        if (!rst_n) begin
          am_q <= 1'b0;
          bm_q <= 1'b0;
        end else if (adv) begin
          am_q <= src_am;
          bm_q <= src_bm;
        end
      end
    end else begin : g_ovf
      logic ovf_q;
      always_ff @(posedge clk or negedge rst_n) begin : ovf_reg
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= (src_am == src_bm) & (chunk_sum[CHUNK-1] != src_am);
        end
      end
    end
`endif
  end

  assign in_ready  = g_stage[0].adv;
  assign out_valid = g_stage[STAGES-1].vld;
  assign sum       = g_stage[STAGES-1].done_q;
  assign cout      = g_stage[STAGES-1].cy;
`ifdef PIPE_ADDER_OVF_EN
  assign ovf       = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule
